// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional macro MULDIV_EARLY_TERM_EN: multiply exits once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  // acc_r holds the running product, or {remainder, quotient/dividend} when dividing
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 is_div_r;
  logic                 neg_res_r;
  logic                 neg_rem_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 signed_op_s;
  logic                 div_zero_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   mul_acc_s;
  logic [WIDTH-1:0]     mplier_nxt_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic                 div_ok_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   div_acc_s;
  logic                 last_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;

  // Operand conditioning, one iteration step of each algorithm, and final sign fix-up
  always_comb begin
    signed_op_s  = ~op[0];
    div_zero_s   = op[1] && (b == {WIDTH{1'b0}});
    a_mag_s      = (signed_op_s && a[WIDTH-1]) ? -a : a;
    b_mag_s      = (signed_op_s && b[WIDTH-1]) ? -b : b;

    mul_acc_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};

    div_shift_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s   = div_shift_s - {1'b0, mplier_r};
    div_ok_s     = ~div_diff_s[WIDTH];
    div_rem_s    = div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
    div_acc_s    = {div_rem_s, acc_r[WIDTH-2:0], div_ok_s};

    last_s       = (cnt_r == CNT_LAST);

    prod_s       = neg_res_r ? -acc_r : acc_r;
    quot_s       = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s        = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div_zero_s) begin
            state_s = FIX;
          end else if (op[1]) begin
            state_s = DIV;
`ifdef MULDIV_EARLY_TERM_EN
          end else if (b_mag_s == {WIDTH{1'b0}}) begin
            state_s = FIX;
`endif
          end else begin
            state_s = MUL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (last_s) begin
          state_s = FIX;
`ifdef MULDIV_EARLY_TERM_EN
        end else if (mplier_nxt_s == {WIDTH{1'b0}}) begin
          state_s = FIX;
`endif
        end else begin
          state_s = MUL;
        end
      end
      DIV: begin
        if (last_s) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, HI/LO architectural registers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (hi_we) begin
            hi_r <= wd;
          end
          if (lo_we) begin
            lo_r <= wd;
          end
          if (start) begin
            cnt_r    <= CNT_ZERO;
            is_div_r <= op[1];
            mplier_r <= b_mag_s;
            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
            // A zero divisor pre-loads the architected result and bypasses sign fix-up
            if (div_zero_s) begin
              acc_r     <= {a, {WIDTH{1'b1}}};
              neg_res_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else begin
              acc_r     <= op[1] ? {{WIDTH{1'b0}}, a_mag_s} : {(2*WIDTH){1'b0}};
              neg_res_r <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_r <= signed_op_s && op[1] && a[WIDTH-1];
            end
          end
        end
        MUL: begin
          acc_r    <= mul_acc_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= mplier_nxt_s;
          cnt_r    <= (state_s == FIX) ? CNT_ZERO : cnt_r + CNT_ONE;
        end
        DIV: begin
          acc_r <= div_acc_s;
          cnt_r <= (state_s == FIX) ? CNT_ZERO : cnt_r + CNT_ONE;
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_s;
            lo_r <= quot_s;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
